huffman_dec: RTL

//  Decoder/unpacker paired with Huffman_enc. Takes the packed W-bit words the encoder emits,

---
 rtl/huffman_dec_if.sv | 29 ++
 rtl/huffman_dec.sv | 104 ++++++++++
 2 files changed

// File: rtl/huffman_dec_if.sv
// Stream bundle for the Huffman decoder: packed-word input, decoded-symbol output, fill-count debug.
// A word on d_in is transferred on a rising edge where en_in & rdy_in; rdy_in never depends on en_in.
interface huffman_dec_if #(
  parameter int W = 8,
  parameter int C = 4
);
  localparam int CW = $clog2(2 * W + 1);

  logic [W-1:0]  d_in;
  logic          en_in;
  logic          rdy_in;
  logic          flush;
  logic [W-1:0]  d_out;
  logic [C-1:0]  w_out;
  logic [C-1:0]  sym_out;
  logic          en_out;
  logic          err_out;
  logic [CW-1:0] cnt;

  modport master (
    output d_in, en_in, flush,
    input  rdy_in, d_out, w_out, sym_out, en_out, err_out, cnt
  );

  modport slave (
    input  d_in, en_in, flush,
    output rdy_in, d_out, w_out, sym_out, en_out, err_out, cnt
  );
endinterface

// File: rtl/huffman_dec.sv
// Unpacks MSB-first W-bit words into prefix codes (k ones, a zero, one value bit), one symbol per cycle.
// Bits below the fill count are always zero, so the leading-ones scan never sees stale data.
module huffman_dec #(
  parameter int W = 8,
  parameter int C = 4
) (
  input logic           clk,
  input logic           rst,
  huffman_dec_if.slave  bus
);
  localparam int CW = $clog2(2 * W + 1);
  localparam int IW = $clog2(2 * W);

  logic [2*W-1:0] bits;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   d_q;
  logic [C-1:0]   w_q;
  logic [C-1:0]   sym_q;
  logic           en_q;
  logic           err_q;

  logic [W-1:0]   top;
  logic [W-1:0]   scan;
  logic [C-1:0]   k;
  logic           run;
  logic [CW-1:0]  width;
  logic [IW-1:0]  vidx;
  logic           v;
  logic           valid;
  logic           invalid;
  logic [CW-1:0]  used;
  logic [W-1:0]   code;
  logic [C-1:0]   sym;
  logic           accept;
  logic [CW-1:0]  rem_cnt;
  logic [2*W-1:0] rem_bits;
  logic [2*W-1:0] ins;
  logic [2*W-1:0] next_bits;
  logic [CW-1:0]  next_cnt;

  assign top = bits[2*W-1 -: W];

  // Leading-ones count over the top W-1 bits, so k saturates at W-1.
  always_comb begin
    k    = '0;
    run  = 1'b1;
    scan = top;
    for (int i = 0; i < W - 1; i++) begin
      if (run && scan[W-1]) k = k + C'(1);
      else                  run = 1'b0;
      scan = scan << 1;
    end
  end

  assign width   = CW'(k) + CW'(2);
  assign vidx    = IW'(2 * W - 2) - IW'(k);
  assign v       = bits[vidx];
  assign valid   = (k <= C'(W - 2)) && (cnt >= width);
  assign invalid = (k == C'(W - 1)) && (cnt >= CW'(W));
  assign used    = valid ? width : (invalid ? CW'(W) : '0);
  assign code    = top & ~({W{1'b1}} >> width);
  assign sym     = (k << 1) | C'(v);

  assign accept    = bus.en_in && bus.rdy_in;
  assign rem_cnt   = cnt - used;
  assign rem_bits  = bits << used;
  assign ins       = {bus.d_in, {W{1'b0}}} >> rem_cnt;
  assign next_bits = accept ? (rem_bits | ins) : rem_bits;
  assign next_cnt  = rem_cnt + (accept ? CW'(W) : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bits  <= '0;
      cnt   <= '0;
      d_q   <= '0;
      w_q   <= '0;
      sym_q <= '0;
      en_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (bus.flush) begin
      bits <= '0;
      cnt  <= '0;
      en_q <= 1'b0;
    end else begin
      bits <= next_bits;
      cnt  <= next_cnt;
      en_q <= valid;
      if (valid) begin
        d_q   <= code;
        w_q   <= C'(width);
        sym_q <= sym;
      end
      if (invalid) err_q <= 1'b1;
    end
  end

  assign bus.rdy_in  = (cnt <= CW'(W));
  assign bus.d_out   = d_q;
  assign bus.w_out   = w_q;
  assign bus.sym_out = sym_q;
  assign bus.en_out  = en_q;
  assign bus.err_out = err_q;
  assign bus.cnt     = cnt;
endmodule
